// File: rtl/midterm2_led_sequencer_if.sv
// Register write bus into the LED sequencer. The bus master is the AXI-Lite
// slave write path, which has already accepted each write.
//   slv_reg_wren  one-cycle strobe per accepted write
//   axi_awaddr    register word address
//   S_AXI_WDATA   write data
interface midterm2_led_sequencer_if;
  logic        slv_reg_wren;
  logic [2:0]  axi_awaddr;
  logic [31:0] S_AXI_WDATA;

  modport master (output slv_reg_wren, output axi_awaddr, output S_AXI_WDATA);
  modport slave  (input  slv_reg_wren, input  axi_awaddr, input  S_AXI_WDATA);
endinterface

// File: rtl/midterm2_led_sequencer.sv
// Register-programmed LED pattern controller.
// Write-only registers CTRL (0: [0] en, [2:1] mode), PATTERN (1) and
// PERIOD (2) are loaded from the write bus. A prescaler produces a step tick
// every PERIOD cycles, on which the LED bus advances according to the mode:
// static, blink, rotate or bounce.
//   S_AXI_ACLK     clock, rising edge
//   S_AXI_ARESETN  synchronous active-low reset
//   wr             register write bus (slave side)
//   LED            registered LED drive
//   step           one-cycle pulse on every pattern advance
//   running        registered CTRL.en
module midterm2_led_sequencer #(
  parameter int unsigned LED_WIDTH    = 8,
  parameter int unsigned PERIOD_WIDTH = 24
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  midterm2_led_sequencer_if.slave  wr,
  output logic [LED_WIDTH-1:0]     LED,
  output logic                     step,
  output logic                     running
);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } phase_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  logic                    en_q, en_d;
  mode_e                   mode_q, mode_d;
  logic [LED_WIDTH-1:0]    pattern_q, pattern_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  phase_e                  phase_q, phase_d;
  dir_e                    dir_q, dir_d;
  logic [LED_WIDTH-1:0]    led_q, led_d;
  logic                    step_q, step_d;

  logic wr_hit;
  logic tick;
  logic unused_wdata;

  // Fields take only the low WDATA bits; the rest are deliberately dropped.
  assign unused_wdata = ^wr.S_AXI_WDATA;

  // Only the three mapped addresses cause a write side effect.
  assign wr_hit = wr.slv_reg_wren && (wr.axi_awaddr < 3'd3);
  assign tick   = en_q && (period_q != '0) &&
                  (cnt_q == period_q - PERIOD_WIDTH'(1));

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      en_q      <= 1'b0;
      mode_q    <= MODE_STATIC;
      pattern_q <= '0;
      period_q  <= '0;
      cnt_q     <= '0;
      phase_q   <= PHASE_ON;
      dir_q     <= DIR_LEFT;
      led_q     <= '0;
      step_q    <= 1'b0;
    end else begin
      en_q      <= en_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      dir_q     <= dir_d;
      led_q     <= led_d;
      step_q    <= step_d;
    end
  end

  always_comb begin
    en_d      = en_q;
    mode_d    = mode_q;
    pattern_d = pattern_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    dir_d     = dir_q;
    led_d     = led_q;
    step_d    = 1'b0;

    if (wr_hit) begin
      // A register write restarts the sequence from the freshly written
      // values and swallows any tick landing on the same edge.
      case (wr.axi_awaddr)
        3'd0: begin
          en_d   = wr.S_AXI_WDATA[0];
          mode_d = mode_e'(wr.S_AXI_WDATA[2:1]);
        end
        3'd1:    pattern_d = wr.S_AXI_WDATA[LED_WIDTH-1:0];
        default: period_d  = wr.S_AXI_WDATA[PERIOD_WIDTH-1:0];
      endcase
      cnt_d   = '0;
      phase_d = PHASE_ON;
      dir_d   = DIR_LEFT;
      led_d   = en_d ? pattern_d : '0;
    end else if (!en_q) begin
      cnt_d = '0;
      led_d = '0;
    end else if (period_q == '0) begin
      cnt_d = '0;
      led_d = pattern_q;
    end else if (tick) begin
      cnt_d  = '0;
      step_d = 1'b1;
      case (mode_q)
        MODE_STATIC: led_d = pattern_q;
        MODE_BLINK: begin
          phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
          led_d   = (phase_d == PHASE_ON) ? pattern_q : '0;
        end
        MODE_ROTATE: led_d = {led_q[LED_WIDTH-2:0], led_q[LED_WIDTH-1]};
        default: begin
          if (dir_q == DIR_LEFT) begin
            if (led_q[LED_WIDTH-1]) begin
              dir_d = DIR_RIGHT;
              led_d = led_q >> 1;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              dir_d = DIR_LEFT;
              led_d = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
      endcase
    end else begin
      cnt_d = cnt_q + PERIOD_WIDTH'(1);
    end
  end

  assign LED     = led_q;
  assign step    = step_q;
  assign running = en_q;

endmodule

// File: tb/tb_midterm2_led_sequencer.sv
module tb_midterm2_led_sequencer;
  localparam int unsigned LW = 8;

  logic          clk;
  logic          rst_n;
  logic [LW-1:0] led;
  logic          step;
  logic          running;

  midterm2_led_sequencer_if bus ();

  midterm2_led_sequencer #(
    .LED_WIDTH    (LW),
    .PERIOD_WIDTH (24)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .wr            (bus.slave),
    .LED           (led),
    .step          (step),
    .running       (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: register values plus cycles elapsed since the last
  // restart. The LED value is derived from how many ticks have occurred.
  int unsigned m_en, m_mode, m_pat, m_per, m_el;

  function automatic int unsigned led_after(int unsigned mode, int unsigned p, int unsigned k);
    int unsigned x, r;
    bit right;
    case (mode)
      0: return p;
      1: return (k % 2 == 1) ? 0 : p;
      2: begin
        r = k % LW;
        return ((p << r) | (p >> (LW - r))) & ((1 << LW) - 1);
      end
      default: begin
        x = p;
        right = 1'b0;
        for (int unsigned i = 0; i < k; i++) begin
          if (!right) begin
            if (x & (1 << (LW - 1))) begin right = 1'b1; x = x >> 1; end
            else x = (x << 1) & ((1 << LW) - 1);
          end else begin
            if (x & 1) begin right = 1'b0; x = (x << 1) & ((1 << LW) - 1); end
            else x = x >> 1;
          end
        end
        return x;
      end
    endcase
  endfunction

  task automatic cycle(input bit rn, input bit we, input int unsigned addr, input logic [31:0] data);
    int unsigned e_led, e_step;
    rst_n            = rn;
    bus.slv_reg_wren = we;
    bus.axi_awaddr   = addr[2:0];
    bus.S_AXI_WDATA  = data;
    @(posedge clk);
    if (!rn) begin
      m_en = 0; m_mode = 0; m_pat = 0; m_per = 0; m_el = 0;
    end else if (we && addr < 3) begin
      if (addr == 0) begin m_en = data[0]; m_mode = data[2:1]; end
      else if (addr == 1) m_pat = data[LW-1:0];
      else m_per = data[23:0];
      m_el = 0;
    end else if (m_en != 0 && m_per != 0) begin
      m_el++;
    end
    e_step = (m_en != 0 && m_per != 0 && m_el > 0 && m_el % m_per == 0) ? 1 : 0;
    if (m_en == 0) e_led = 0;
    else if (m_per == 0) e_led = m_pat;
    else e_led = led_after(m_mode, m_pat, m_el / m_per);
    #1;
    chk("led", 32'(led), e_led);
    chk("step", 32'(step), e_step);
    chk("running", 32'(running), m_en);
    rst_n            = 1'b1;
    bus.slv_reg_wren = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, 32'h0);
  endtask

  task automatic wr(input int unsigned addr, input logic [31:0] data);
    cycle(1'b1, 1'b1, addr, data);
  endtask

  initial begin
    logic [31:0] r;
    int unsigned a, sel;
    rst_n = 1'b0;
    bus.slv_reg_wren = 1'b0;
    bus.axi_awaddr   = '0;
    bus.S_AXI_WDATA  = '0;
    m_en = 0; m_mode = 0; m_pat = 0; m_per = 0; m_el = 0;

    cycle(1'b0, 1'b0, 0, 32'h0);
    cycle(1'b0, 1'b1, 0, 32'hFFFF_FFFF);   // reset beats a concurrent write

    // static, PERIOD=0
    wr(1, 32'h0000_00A5); wr(0, 32'h1); wr(2, 32'h0); idle(5);
    // blink, PERIOD=3
    wr(1, 32'h0F); wr(2, 32'd3); wr(0, 32'h3); idle(10);
    // rotate, PERIOD=1
    wr(1, 32'h80); wr(2, 32'd1); wr(0, 32'h5); idle(5);
    // bounce, PERIOD=1
    wr(1, 32'h40); wr(0, 32'h7); idle(12);
    // rotate PERIOD=4, PATTERN write lands on the tick edge
    wr(1, 32'h01); wr(2, 32'd4); wr(0, 32'h5); idle(3);
    wr(1, 32'hFFFF_FF03); idle(6);
    wr(3, 32'hFFFF_FFFF); wr(7, 32'h0); idle(3);
    // reset in the middle of bounce, then restart
    wr(1, 32'h10); wr(2, 32'd2); wr(0, 32'h7); idle(5);
    cycle(1'b0, 1'b0, 0, 32'h0); idle(2);
    wr(1, 32'h10); wr(2, 32'd2); wr(0, 32'h7); idle(6);
    // en=0 mid-run
    wr(0, 32'hFFFF_FFF6); idle(4);

    for (int unsigned i = 0; i < 4000; i++) begin
      r   = $urandom();
      sel = $urandom_range(0, 99);
      if (sel < 2) begin
        cycle(1'b0, $urandom_range(0, 1) == 1, 0, r);
      end else if (sel < 16) begin
        a = $urandom_range(0, 5);
        if (a == 2) r = {r[31:24], 24'($urandom_range(0, 6))};
        cycle(1'b1, 1'b1, a, r);
      end else begin
        idle(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
